// File: rtl/test_status_reporter.sv
// Harness-side test-completion endpoint: decodes tohost exit/console commands, acks console
// writes over fromhost, and reports sticky pass/fail status with an optional inactivity watchdog.
//
// state | meaning
// RUN   | accepting tohost commands, watchdog counting
// ACK   | console ack presented on fromhost, waiting for fromhost_ready
// PASS  | terminal: test passed
// FAIL  | terminal: test failed, io_code holds the reason
module test_status_reporter #(
  parameter int unsigned WATCHDOG_CYCLES = 0,
  parameter int unsigned CODE_W          = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tohost_valid,
  output logic              tohost_ready,
  input  logic [63:0]       tohost_bits,
  output logic              fromhost_valid,
  input  logic              fromhost_ready,
  output logic [63:0]       fromhost_bits,
  output logic              console_valid,
  output logic [7:0]        console_char,
  input  logic              io_activity,
  output logic              io_success,
  output logic              io_failure,
  output logic [CODE_W-1:0] io_code
);

  typedef enum logic [1:0] {ST_RUN, ST_ACK, ST_PASS, ST_FAIL} state_t;

  localparam int unsigned WD_W = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((WATCHDOG_CYCLES > 0) ? WATCHDOG_CYCLES - 1 : 0);
  localparam logic [63:0] ACK_WORD = {8'd1, 8'd1, 48'd1};
  localparam logic [CODE_W-1:0] CODE_BAD_CMD  = {{(CODE_W-1){1'b1}}, 1'b0};
  localparam logic [CODE_W-1:0] CODE_WATCHDOG = {CODE_W{1'b1}};

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [WD_W-1:0]   wd_cnt_q;
  logic              console_valid_q;
  logic [7:0]        console_char_q;

  logic [7:0]  dev, cmd;
  logic [47:0] payload;
  logic        accept, is_exit, is_console;
  logic        wd_counting, wd_clear, wd_expire;

  assign dev     = tohost_bits[63:56];
  assign cmd     = tohost_bits[55:48];
  assign payload = tohost_bits[47:0];

  assign accept     = tohost_valid && (state_q == ST_RUN);
  assign is_exit    = (dev == 8'd0) && (cmd == 8'd0) && payload[0];
  assign is_console = (dev == 8'd1) && (cmd == 8'd1);

  // Expiry fires on the cycle the count would reach WATCHDOG_CYCLES, so FAIL is
  // visible exactly WATCHDOG_CYCLES idle cycles after the last clear.
  assign wd_counting = (WATCHDOG_CYCLES > 0) && ((state_q == ST_RUN) || (state_q == ST_ACK));
  assign wd_clear    = io_activity || accept;
  assign wd_expire   = wd_counting && !wd_clear && (wd_cnt_q == WD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q        <= '0;
      console_valid_q <= 1'b0;
      console_char_q  <= '0;
    end else begin
      if (wd_counting) begin
        if (wd_clear)
          wd_cnt_q <= '0;
        else if (wd_cnt_q != WD_MAX)
          wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      console_valid_q <= accept && is_console;
      console_char_q  <= (accept && is_console) ? payload[7:0] : 8'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_RUN: begin
        // An accepted command takes priority over a coincident watchdog expiry.
        if (accept) begin
          if (is_exit) begin
            if (payload[47:1] == 47'd0) begin
              state_d = ST_PASS;
            end else begin
              state_d = ST_FAIL;
              code_d  = CODE_W'(payload >> 1);
            end
          end else if (is_console) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_FAIL;
            code_d  = CODE_BAD_CMD;
          end
        end else if (wd_expire) begin
          state_d = ST_FAIL;
          code_d  = CODE_WATCHDOG;
        end
      end
      ST_ACK: begin
        if (wd_expire) begin
          state_d = ST_FAIL;
          code_d  = CODE_WATCHDOG;
        end else if (fromhost_ready) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    tohost_ready   = (state_q == ST_RUN);
    fromhost_valid = (state_q == ST_ACK);
    fromhost_bits  = (state_q == ST_ACK) ? ACK_WORD : 64'd0;
    console_valid  = console_valid_q;
    console_char   = console_char_q;
    io_success     = (state_q == ST_PASS);
    io_failure     = (state_q == ST_FAIL);
    io_code        = (state_q == ST_FAIL) ? code_q : '0;
  end

endmodule
